// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Word-wide memory bus between the memory access unit and a memory.
//   mem_req    : transfer request, held until the transfer is acknowledged
//   mem_we     : 1 = write, 0 = read
//   mem_addr   : word-aligned byte address ([1:0] = 2'b00)
//   mem_wdata  : full-word write data
//   mem_rdata  : full-word read data
//   mem_ack    : a transfer completes on a rising edge with mem_req && mem_ack
//   log_valid  : store-commit trace strobe, high on the edge a write commits
//   log_pc     : PC of the store being committed (valid with log_valid)
// Modports: master (the access unit), slave (the memory / trace observer).
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        log_valid;
  logic [31:0] log_pc;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, log_valid, log_pc,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, log_valid, log_pc,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Executes one CPU load/store at a time over a word-wide memory bus.
// Sub-word stores are done as read-modify-write; loads are lane-selected and
// sign/zero extended. Misaligned requests finish immediately with addr_err,
// transfers that wait more than TIMEOUT cycles are aborted with bus_err.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : request strobe, only sampled while idle
//   op              : 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   addr/wdata/pc   : byte address, store data, issuing PC
//   busy            : request in progress
//   done            : one-cycle completion pulse
//   rdata           : extended load result (held until the next accepted start)
//   addr_err/bus_err: misaligned / timed-out request (held like rdata)
//   bus             : memory bus, master side
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                op,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [31:0]               pc,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic                      addr_err,
  output logic                      bus_err,
  mem_access_unit_if.master         bus
);

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The counter never holds more than TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  function automatic logic misaligned(op_e o, logic [1:0] a);
    case (o)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

  // Little-endian lane select: byte lane = a, half lane = a[1].
  function automatic logic [31:0] load_extend(op_e o, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (o)
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'h0000, h};
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'h000000, b};
      default: load_extend = w;
    endcase
  endfunction

  // Replace only the addressed lane of the word just read.
  function automatic logic [31:0] store_merge(op_e o, logic [1:0] a, logic [31:0] w,
                                              logic [31:0] d);
    store_merge = w;
    if (o == OP_SH) store_merge[{a[1], 4'b0000} +: 16] = d[15:0];
    else            store_merge[{a, 3'b000} +: 8]      = d[7:0];
  endfunction

  state_e           state_q,     state_d;
  op_e              op_q,        op_d;
  logic [31:0]      addr_q,      addr_d;
  logic [31:0]      wdata_q,     wdata_d;
  logic [31:0]      pc_q,        pc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic             addr_err_q,  addr_err_d;
  logic             bus_err_q,   bus_err_d;
  logic             mem_req_q,   mem_req_d;
  logic             mem_we_q,    mem_we_d;
  logic [31:0]      mem_addr_q,  mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  op_e  op_in;
  logic timed_out;

  assign op_in     = op_e'(op);
  // This wait cycle would bring the counter to TIMEOUT: abort instead.
  assign timed_out = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op_in;
          addr_d     = addr;
          wdata_d    = wdata;
          pc_d       = pc;
          cnt_d      = '0;
          rdata_d    = '0;
          addr_err_d = 1'b0;
          bus_err_d  = 1'b0;
          if (misaligned(op_in, addr[1:0])) begin
            state_d    = DONE;
            addr_err_d = 1'b1;
          end else begin
            mem_addr_d = {addr[31:2], 2'b00};
            if (op_in == OP_SW) begin
              state_d     = WRITE;
              mem_wdata_d = wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state_d = READ;
            end
          end
        end
      end

      READ: begin
        if (bus.mem_ack) begin
          if (op_q == OP_SH || op_q == OP_SB) begin
            state_d     = WRITE;
            cnt_d       = '0;
            mem_wdata_d = store_merge(op_q, addr_q[1:0], bus.mem_rdata, wdata_q);
          end else begin
            state_d = DONE;
            rdata_d = load_extend(op_q, addr_q[1:0], bus.mem_rdata);
          end
        end else if (timed_out) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WRITE: begin
        if (bus.mem_ack) begin
          state_d = DONE;
        end else if (timed_out) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    mem_req_d = (state_d == READ) || (state_d == WRITE);
    mem_we_d  = (state_d == WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign addr_err      = addr_err_q;
  assign bus_err       = bus_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Store-commit trace: a write commits on its ack edge unless reset wins.
  assign bus.log_valid = (state_q == WRITE) && bus.mem_ack && !reset;
  assign bus.log_pc    = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit (TIMEOUT = 4). A small word memory
// answers the bus with a programmable number of wait cycles (or ack held
// high / stuck low) and prints the store log line from the commit trace.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc;
  logic        busy, done, addr_err, bus_err;
  logic [31:0] rdata;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .pc       (pc),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .addr_err (addr_err),
    .bus_err  (bus_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Memory model and bus observers.
  logic [31:0] mem [16];
  bit          ack_hi;
  bit          ack_stuck;
  int          ack_wait;
  int          wait_cnt;
  int          req_cycles;
  int          done_count;
  int          log_count;
  logic [31:0] last_log_pc, last_log_addr, last_log_data;

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (ack_hi)         bus.mem_ack = 1'b1;
    else if (ack_stuck) bus.mem_ack = 1'b0;
    else                bus.mem_ack = (bus.mem_req === 1'b1) && (wait_cnt >= ack_wait);
    bus.mem_rdata = mem[bus.mem_addr[5:2]];
  end

  always @(posedge clk) begin
    if (bus.mem_req === 1'b1) req_cycles++;
    if (done === 1'b1) done_count++;
    if (bus.log_valid === 1'b1) begin
      log_count++;
      last_log_pc   = bus.log_pc;
      last_log_addr = bus.mem_addr;
      last_log_data = bus.mem_wdata;
      $display("@%08h: *%08h <= %08h", bus.log_pc, bus.mem_addr, bus.mem_wdata);
    end
    if (reset !== 1'b0 || bus.mem_req !== 1'b1) begin
      wait_cnt = 0;
    end else if (bus.mem_ack === 1'b1) begin
      wait_cnt = 0;
      if (bus.mem_we === 1'b1) mem[bus.mem_addr[5:2]] = bus.mem_wdata;
    end else begin
      wait_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_rdata"},     rdata,              32'd0);
    check({tag, "_addr_err"},  32'(addr_err),      32'd0);
    check({tag, "_bus_err"},   32'(bus_err),       32'd0);
    check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
  endtask

  // Drive one start pulse; returns at the falling edge one cycle after the
  // start edge (latency 1).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] p);
    @(negedge clk);
    op = o; addr = a; wdata = wd; pc = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles from the start edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction with latency, result and one-cycle-pulse checks.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] p, input int exp_lat,
                        input logic [31:0] exp_rdata);
    int lat;
    issue(o, a, wd, p);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, logs0, reqs0, dc0;
    reset = 1'b1; start = 1'b0; op = LW; addr = '0; wdata = '0; pc = '0;
    ack_hi = 1'b0; ack_stuck = 1'b0; ack_wait = 0; wait_cnt = 0;
    req_cycles = 0; done_count = 0; log_count = 0;
    last_log_pc = '0; last_log_addr = '0; last_log_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0]  = 32'h0BAD_C0DE;
    mem[4]  = 32'h80FF_1234;
    mem[8]  = 32'h1122_3344;
    mem[12] = 32'hCAFE_F00D;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // LB / LBU with ack held high, including while idle.
    ack_hi = 1'b1;
    run_op("lb", LB, 32'h0000_0013, 32'h0, 32'h100, 2, 32'hFFFF_FF80);
    check("lb_idle_with_ack", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("lb_rdata_held", rdata, 32'hFFFF_FF80);
    run_op("lbu", LBU, 32'h0000_0013, 32'h0, 32'h104, 2, 32'h0000_0080);
    ack_hi = 1'b0;

    // SH read-modify-write with two wait cycles per transfer.
    ack_wait = 2;
    logs0 = log_count;
    issue(SH, 32'h0000_0022, 32'hAAAA_BEEF, 32'h200);
    check("sh_read_req", 32'(bus.mem_req), 32'd1);
    check("sh_read_we", 32'(bus.mem_we), 32'd0);
    check("sh_read_addr", bus.mem_addr, 32'h0000_0020);
    wait_done(lat);
    check("sh_latency", 32'(lat), 32'd7);
    check("sh_mem", mem[8], 32'hBEEF_3344);
    check("sh_log_count", 32'(log_count), 32'(logs0 + 1));
    check("sh_log_pc", last_log_pc, 32'h0000_0200);
    check("sh_log_addr", last_log_addr, 32'h0000_0020);
    check("sh_log_data", last_log_data, 32'hBEEF_3344);
    @(negedge clk);
    check("sh_done_pulse", 32'(done), 32'd0);

    // Halfword loads of the merged word, zero-wait memory.
    ack_wait = 0;
    run_op("lh", LH, 32'h0000_0022, 32'h0, 32'h204, 2, 32'hFFFF_BEEF);
    run_op("lhu", LHU, 32'h0000_0020, 32'h0, 32'h208, 2, 32'h0000_3344);
    run_op("lw_plain", LW, 32'h0000_0010, 32'h0, 32'h20C, 2, 32'h80FF_1234);

    // Misaligned LW: immediate done, no bus activity.
    reqs0 = req_cycles;
    issue(LW, 32'h0000_0006, 32'h0, 32'h300);
    check("lw_mis_done", 32'(done), 32'd1);
    check("lw_mis_addr_err", 32'(addr_err), 32'd1);
    check("lw_mis_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    check("lw_mis_done_pulse", 32'(done), 32'd0);
    check("lw_mis_no_req", 32'(req_cycles), 32'(reqs0));
    check("lw_mis_err_held", 32'(addr_err), 32'd1);

    // Misaligned SH: addr[0] set.
    issue(SH, 32'h0000_0021, 32'h1234_5678, 32'h304);
    check("sh_mis_addr_err", 32'(addr_err), 32'd1);
    check("sh_mis_no_req", 32'(req_cycles), 32'(reqs0));
    check("sh_mis_mem", mem[8], 32'hBEEF_3344);
    @(negedge clk);

    // Aligned SW and SB.
    logs0 = log_count;
    run_op("sw", SW, 32'h0000_0004, 32'hDEAD_BEEF, 32'h400, 2, 32'h0);
    check("sw_mem", mem[1], 32'hDEAD_BEEF);
    check("sw_log_pc", last_log_pc, 32'h0000_0400);
    check("sw_log_addr", last_log_addr, 32'h0000_0004);
    run_op("sb", SB, 32'h0000_0005, 32'h0000_00A5, 32'h404, 3, 32'h0);
    check("sb_mem", mem[1], 32'hDEAD_A5EF);
    check("sb_log_count", 32'(log_count), 32'(logs0 + 2));

    // SW timeout: four wait cycles then abort.
    ack_stuck = 1'b1;
    logs0 = log_count;
    issue(SW, 32'h0000_0008, 32'h1234_5678, 32'h500);
    check("to_write_we", 32'(bus.mem_we), 32'd1);
    wait_done(lat);
    check("to_latency", 32'(lat), 32'd5);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_addr_err", 32'(addr_err), 32'd0);
    check("to_req_dropped", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    check("to_idle", 32'(busy), 32'd0);
    check("to_mem", mem[2], 32'h0000_0000);
    check("to_no_log", 32'(log_count), 32'(logs0));
    ack_stuck = 1'b0;

    // Reset during the SB read wait.
    ack_wait = 3;
    logs0 = log_count;
    issue(SB, 32'h0000_0031, 32'h0000_0077, 32'h600);
    check("rst_sb_req", 32'(bus.mem_req), 32'd1);
    check("rst_sb_busy", 32'(busy), 32'd1);
    @(negedge clk);
    dc0 = done_count;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_done", 32'(done_count), 32'(dc0));
    check("rst_no_log", 32'(log_count), 32'(logs0));
    check("rst_mem", mem[12], 32'hCAFE_F00D);
    check("rst_idle", 32'(busy), 32'd0);
    ack_wait = 0;
    run_op("rst_lw", LW, 32'h0000_0030, 32'h0, 32'h604, 2, 32'hCAFE_F00D);

    // Start held high while busy (READ then DONE) is ignored.
    ack_wait = 1;
    dc0 = done_count;
    issue(LW, 32'h0000_0010, 32'h0, 32'h700);
    op = SW; addr = 32'h0000_0000; wdata = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_rdata", rdata, 32'h80FF_1234);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_start_one_done", 32'(done_count), 32'(dc0 + 1));
    check("busy_start_mem", mem[0], 32'h0BAD_C0DE);
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the maximum number of wait cycles per bus transfer before abort.
REQ-002 The block SHALL have input clk, 1 bit: the clock; all state changes on the rising edge.
REQ-003 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input start, 1 bit: the CPU request strobe, sampled only in IDLE.
REQ-005 The block SHALL have input op, 3 bits: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 The block SHALL have inputs addr (32 bits, byte address), wdata (32 bits, store data) and pc (32 bits, issuing PC, used for the store log).
REQ-007 The block SHALL have outputs busy (1 bit: not IDLE), done (1 bit: one-cycle completion pulse) and rdata (32 bits: extended load result).
REQ-008 The block SHALL have outputs addr_err (1 bit: misaligned request, valid with done) and bus_err (1 bit: transfer timeout, valid with done).
REQ-009 The block SHALL have outputs mem_req (1 bit: transfer request), mem_we (1 bit: 1=write, 0=read), mem_addr (32 bits, word-aligned, [1:0]=00) and mem_wdata (32 bits: full-word write data).
REQ-010 The block SHALL have inputs mem_rdata (32 bits: full-word read data) and mem_ack (1 bit: the transfer completes on an edge where mem_req&&mem_ack).

Function
REQ-011 The FSM SHALL have the states IDLE, READ, WRITE, DONE.
REQ-012 In IDLE with start=1, the block SHALL latch op, addr, wdata and pc.
REQ-013 From IDLE, a misaligned request (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1) SHALL go to DONE with addr_err=1 and SHALL issue no bus transfer.
REQ-014 From IDLE, an aligned load, SH or SB SHALL go to READ, and an aligned SW SHALL go directly to WRITE.
REQ-015 In READ, mem_req=1 and mem_we=0 SHALL hold until mem_ack; on the ack edge the block SHALL capture mem_rdata, then go to DONE for a load or to WRITE for SH/SB.
REQ-016 In WRITE, mem_req=1 and mem_we=1 SHALL hold until mem_ack, then the block SHALL go to DONE.
REQ-017 mem_addr SHALL equal {latched addr[31:2],2'b00} whenever mem_req=1.
REQ-018 Byte lanes SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-019 SW SHALL write mem_wdata = wdata.
REQ-020 SH/SB SHALL perform read-modify-write: the write data is the captured read word with the addressed lane replaced by wdata[15:0] or wdata[7:0] and the other lanes unchanged.
REQ-021 LW SHALL return the word; LH/LB SHALL sign-extend the addressed lane; LHU/LBU SHALL zero-extend it.
REQ-022 In DONE, done=1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-023 rdata, addr_err and bus_err SHALL be valid from the done cycle and held until the next accepted start.
REQ-024 On an accepted store with no error, the block SHALL print "@<pc>: *<mem_addr> <= <mem_wdata>" (8-digit hex) at the WRITE ack edge.
REQ-025 A wait counter SHALL clear on entry to READ/WRITE and increment each cycle without ack; on reaching TIMEOUT the block SHALL drop mem_req next cycle and go to DONE with bus_err=1, leaving memory unmodified.
REQ-026 start while busy SHALL be ignored, with no queueing.
REQ-027 mem_ack outside READ/WRITE SHALL be ignored.
REQ-028 With zero-wait memory (ack held high), latency SHALL be: start edge -> done 2 cycles later for loads/SW, 3 cycles later for SH/SB.
REQ-029 busy SHALL be 1 in READ, WRITE and DONE.

Reset
REQ-030 On reset, the block SHALL go to IDLE and clear the latched request and wait counter.
REQ-031 On reset, outputs SHALL be 0: busy, done, rdata, addr_err, bus_err, mem_req, mem_we, mem_addr, mem_wdata.
REQ-032 Reset mid-transfer SHALL drop mem_req at that edge, produce no done pulse and no log line.
REQ-033 Reset SHALL take priority over start and mem_ack in the same cycle.

Verification
REQ-034 The bench SHALL cover: LB addr=0x0000_0013, memory word 0x80FF_1234, ack high -> done 2 cycles after start, rdata=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-035 The bench SHALL cover: SH addr=0x0000_0022, wdata=0xAAAA_BEEF, memory word 0x1122_3344, 2-cycle ack wait per transfer -> READ then WRITE of 0xBEEF_3344 at mem_addr 0x20, log line printed, done 7 cycles after start.
REQ-036 The bench SHALL cover: LW addr=0x0000_0006 -> done 1 cycle after start, addr_err=1, mem_req never asserted.
REQ-037 The bench SHALL cover: SW with mem_ack stuck low, TIMEOUT=4 -> bus_err=1 with done, no write, no log line, then IDLE.
REQ-038 The bench SHALL cover: reset asserted during the SB READ wait -> all outputs 0 next cycle, no done; a following LW completes normally.
REQ-039 The bench SHALL cover: start pulsed while busy -> ignored; exactly one done per accepted start.
